nlb_gram_spx: RTL and testbench
===============================

Name: nlb_gram_spx

Overview:
Parametrised single-port synchronous RAM, the successor to the team's basic single-port GRAM primitive. Adds:
- per-lane write enables
- a selectable read-during-write mode
- an optional output pipeline register with a read-valid strobe
- a post-reset clear sequencer that zeroes every entry before accepting traffic

Used as the generic scratch/table memory inside NLB datapaths where deterministic initial contents and known read latency are required.

Parameters:
BUS_SIZE_ADDR, 11, address width; depth = 2**BUS_SIZE_ADDR
BUS_SIZE_DATA, 32, data width; must be a multiple of NUM_LANES
NUM_LANES, 4, number of write-enable lanes; lane width LW = BUS_SIZE_DATA/NUM_LANES
RD_MODE, 0, read-during-write behaviour: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
INIT_CLR, 1, 1 = zero all entries after reset; 0 = no clear, ready immediately
GRAM_STYLE, `GRAM_AUTO, synthesis RAM style attribute (GRAM_AUTO/GRAM_BLCK/GRAM_DIST)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
re  input  1  read request
we  input  NUM_LANES  per-lane write enable; lane i covers din[i*LW +: LW]
addr  input  BUS_SIZE_ADDR  shared read/write address
din  input  BUS_SIZE_DATA  write data
dout  output  BUS_SIZE_DATA  read data
dout_vld  output  1  one-cycle strobe: dout carries data for an accepted read
init_done  output  1  high once the clear sequence is complete (constant 1 after reset if INIT_CLR=0)

Behaviour:
- Reset is asynchronous, active-high, on rst. Values while rst is high:
  - dout = 0, dout_vld = 0, and all pipeline registers = 0.
  - clear counter = 0; init_done = 0 if INIT_CLR=1, else 1.
  - RAM array contents are not reset by rst directly.
- FSM, two states: CLR, RUN.
  - Reset enters CLR if INIT_CLR=1, else RUN.
  - CLR: each cycle write 0 to all lanes at clr_cnt, then increment. On clr_cnt = 2**BUS_SIZE_ADDR-1, write it and go to RUN.
  - init_done rises the cycle after the last clear write. Clear duration is exactly 2**BUS_SIZE_ADDR cycles after rst deassertion.
- In CLR, re/we/addr/din are ignored: no array update and no dout_vld.
- rst asserted mid-clear restarts the clear from address 0.
- Accepted read: re=1 in RUN, not suppressed by RD_MODE.
  - OUT_REG=0: dout and dout_vld update at edge N+1.
  - OUT_REG=1: dout and dout_vld update at edge N+2.
- dout holds its last value when no read completes. dout_vld is high for exactly one cycle per accepted read.
- Back-to-back reads every cycle are supported at full throughput.
- Writes: at the edge, lane i of ram[addr] <= din lane i when we[i]=1. Lanes with we[i]=0 are unchanged. we=0 with re=0 is idle.
- re=1 with we!=0 in the same cycle (same address by construction):
  - NO_CHANGE: write happens; read suppressed; dout holds; no dout_vld. This matches legacy GRAM behaviour.
  - READ_FIRST: dout = old word; dout_vld asserted.
  - WRITE_FIRST: dout = merged word (new data on enabled lanes, old data elsewhere); dout_vld asserted.
- Read of an address written in the previous cycle always returns the updated data (no stale window).
- Address wrap: addr is used modulo depth by width; there is no out-of-range condition.
- Illegal parameters: BUS_SIZE_DATA % NUM_LANES != 0 or RD_MODE > 2 triggers a simulation-time $error at elaboration.

Test Plan:
1. INIT_CLR=1, BUS_SIZE_ADDR=4: release rst.
   -> init_done rises exactly 16 cycles later.
   -> Read all 16 addresses: each returns 0x00000000 with dout_vld.
   -> Stimulus driven during CLR has no effect.
2. Write addr 5 = 0xAABBCCDD, we=4'b1111, then write 0x11223344 with we=4'b0101; read addr 5.
   -> dout = 0xAA22CC44.
   -> Latency is 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1).
3. Addr 7 holds 0x12345678; re=1 with we=4'b1111, din=0x9ABCDEF0.
   -> RD_MODE=0: no dout_vld, dout unchanged.
   -> RD_MODE=1: dout=0x12345678.
   -> RD_MODE=2: dout=0x9ABCDEF0.
4. Streaming reads of addr 0..15 on consecutive cycles with OUT_REG=1.
   -> 16 consecutive dout_vld pulses, data in order, first at cycle 2.
5. Assert rst at clr_cnt=9, release.
   -> Clear restarts at 0; init_done after a full 16 cycles.
   -> dout=0 and dout_vld=0 during rst.
6. INIT_CLR=0.
   -> init_done=1 during and after reset.
   -> A write then read one cycle later returns the written data.

Source files
------------

// File: rtl/nlb_gram_spx.sv
// nlb_gram_spx: single-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and a post-reset clear sequencer.
`ifndef GRAM_AUTO
`define GRAM_AUTO "auto"
`endif
`ifndef GRAM_BLCK
`define GRAM_BLCK "block"
`endif
`ifndef GRAM_DIST
`define GRAM_DIST "distributed"
`endif

module nlb_gram_spx #(
  parameter int    BUS_SIZE_ADDR = 11,
  parameter int    BUS_SIZE_DATA = 32,
  parameter int    NUM_LANES     = 4,
  parameter int    RD_MODE       = 0,
  parameter int    OUT_REG       = 0,
  parameter int    INIT_CLR      = 1,
  parameter string GRAM_STYLE    = `GRAM_AUTO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [NUM_LANES-1:0]     we,
  input  logic [BUS_SIZE_ADDR-1:0] addr,
  input  logic [BUS_SIZE_DATA-1:0] din,
  output logic [BUS_SIZE_DATA-1:0] dout,
  output logic                     dout_vld,
  output logic                     init_done
);

  localparam int LW    = BUS_SIZE_DATA / NUM_LANES;
  localparam int DEPTH = 1 << BUS_SIZE_ADDR;
  localparam logic [BUS_SIZE_ADDR-1:0] LAST_ADDR = '1;

  if (BUS_SIZE_DATA % NUM_LANES != 0) begin : g_bad_lanes
    $error("nlb_gram_spx: BUS_SIZE_DATA must be a multiple of NUM_LANES");
  end
  if (RD_MODE < 0 || RD_MODE > 2) begin : g_bad_rd_mode
    $error("nlb_gram_spx: RD_MODE must be 0, 1 or 2");
  end

  typedef enum logic {S_CLR, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_CLR != 0) ? S_CLR : S_RUN;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [BUS_SIZE_ADDR-1:0]   r_clr_cnt;
  logic                       w_clr_act;

  logic [NUM_LANES-1:0]       w_wen;
  logic [BUS_SIZE_ADDR-1:0]   w_waddr;
  logic [BUS_SIZE_DATA-1:0]   w_wdata;
  logic                       w_rd_acc;
  logic [BUS_SIZE_DATA-1:0]   w_mem_q;
  logic [BUS_SIZE_DATA-1:0]   w_rd_word;
  logic [BUS_SIZE_DATA-1:0]   r_rd_data;
  logic                       r_rd_vld;

  (* ram_style = GRAM_STYLE *) logic [BUS_SIZE_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == S_CLR && r_clr_cnt == LAST_ADDR) begin
      w_state_next = S_RUN;
    end
  end

  always_comb begin
    w_clr_act = (r_state == S_CLR);
    init_done = (r_state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (w_clr_act) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // The clear sequencer owns the write port completely while it runs.
  assign w_wen    = w_clr_act ? {NUM_LANES{1'b1}} : we;
  assign w_waddr  = w_clr_act ? r_clr_cnt : addr;
  assign w_wdata  = w_clr_act ? '0 : din;
  assign w_rd_acc = init_done && re && !((RD_MODE == 0) && (|we));

  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_wen[l]) begin
        r_mem[w_waddr][l*LW +: LW] <= w_wdata[l*LW +: LW];
      end
    end
  end

  assign w_mem_q = r_mem[addr];

  // Write-first forwards the incoming lanes; other modes see the pre-write word.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rd_lane
    assign w_rd_word[gi*LW +: LW] = ((RD_MODE == 2) && we[gi]) ? din[gi*LW +: LW]
                                                                : w_mem_q[gi*LW +: LW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [BUS_SIZE_DATA-1:0] r_dout;
    logic                     r_dout_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout     <= '0;
        r_dout_vld <= 1'b0;
      end else begin
        r_dout_vld <= r_rd_vld;
        if (r_rd_vld) begin
          r_dout <= r_rd_data;
        end
      end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
  end else begin : g_out_direct
    assign dout     = r_rd_data;
    assign dout_vld = r_rd_vld;
  end

endmodule

// File: tb/tb_nlb_gram_spx.sv
// Bench for nlb_gram_spx: four instances (NO_CHANGE, READ_FIRST+OUT_REG, WRITE_FIRST,
// no-clear) checked against a reference memory model through per-instance scoreboards.
module tb_nlb_gram_spx;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        re;
  logic [3:0]  we;
  logic [3:0]  addr;
  logic [31:0] din;
  logic        re_d;
  logic [3:0]  we_d;
  logic [3:0]  addr_d;
  logic [31:0] din_d;

  logic [31:0] dout_w [4];
  logic        vld_w  [4];
  logic        done_w [4];

  logic [31:0] mdl   [16];
  logic [31:0] mdl_d [16];
  logic [31:0] last  [4];
  sb_t         sb_q  [4][$];

  int cyc;
  int checks;
  int fails;

  nlb_gram_spx #(.BUS_SIZE_ADDR(4), .BUS_SIZE_DATA(32), .NUM_LANES(4),
                 .RD_MODE(0), .OUT_REG(0), .INIT_CLR(1)) u_nc (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .din(din),
    .dout(dout_w[0]), .dout_vld(vld_w[0]), .init_done(done_w[0]));

  nlb_gram_spx #(.BUS_SIZE_ADDR(4), .BUS_SIZE_DATA(32), .NUM_LANES(4),
                 .RD_MODE(1), .OUT_REG(1), .INIT_CLR(1)) u_rf (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .din(din),
    .dout(dout_w[1]), .dout_vld(vld_w[1]), .init_done(done_w[1]));

  nlb_gram_spx #(.BUS_SIZE_ADDR(4), .BUS_SIZE_DATA(32), .NUM_LANES(4),
                 .RD_MODE(2), .OUT_REG(0), .INIT_CLR(1)) u_wf (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .din(din),
    .dout(dout_w[2]), .dout_vld(vld_w[2]), .init_done(done_w[2]));

  nlb_gram_spx #(.BUS_SIZE_ADDR(4), .BUS_SIZE_DATA(32), .NUM_LANES(4),
                 .RD_MODE(1), .OUT_REG(0), .INIT_CLR(0)) u_noclr (
    .clk(clk), .rst(rst), .re(re_d), .we(we_d), .addr(addr_d), .din(din_d),
    .dout(dout_w[3]), .dout_vld(vld_w[3]), .init_done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oreg(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  task automatic push(input int k, input logic [31:0] d);
    sb_t e;
    e.data = d;
    e.due  = cyc + 1 + oreg(k);
    sb_q[k].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the shared bus of the three clearing instances for one cycle.
  task automatic drive(input logic r, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] d);
    logic [31:0] old_w;
    logic [31:0] new_w;
    re = r; we = w; addr = a; din = d;
    old_w = mdl[a];
    new_w = old_w;
    for (int l = 0; l < 4; l++) if (w[l]) new_w[l*8 +: 8] = d[l*8 +: 8];
    if (r) begin
      if (w == 4'b0000) begin
        push(0, old_w); push(1, old_w); push(2, old_w);
      end else begin
        push(1, old_w); push(2, new_w);
      end
    end
    mdl[a] = new_w;
    step();
  endtask

  task automatic drive_d(input logic r, input logic [3:0] w, input logic [3:0] a,
                         input logic [31:0] d);
    logic [31:0] new_w;
    re_d = r; we_d = w; addr_d = a; din_d = d;
    new_w = mdl_d[a];
    for (int l = 0; l < 4; l++) if (w[l]) new_w[l*8 +: 8] = d[l*8 +: 8];
    if (r) push(3, mdl_d[a]);
    mdl_d[a] = new_w;
    step();
  endtask

  task automatic idle(input int n);
    re = 1'b0; we = 4'b0000; re_d = 1'b0; we_d = 4'b0000;
    repeat (n) step();
  endtask

  // Random traffic during the clear must be ignored; init_done rises after 16 edges.
  task automatic wait_clear();
    for (int i = 1; i <= 16; i++) begin
      re = 1'b1; we = 4'($urandom); addr = 4'(i); din = $urandom;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        assert (done_w[k] === (i == 16)) else begin
          fails++;
          $error("FAIL init_done dut=%0d edge=%0d observed=%b expected=%b",
                 k, i, done_w[k], (i == 16));
        end
      end
    end
    re = 1'b0; we = 4'b0000;
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (rst) begin
          checks++;
          assert (dout_w[k] === 32'h0) else begin
            fails++; $error("FAIL rst_dout dut=%0d observed=%h expected=0", k, dout_w[k]);
          end
          checks++;
          assert (vld_w[k] === 1'b0) else begin
            fails++; $error("FAIL rst_vld dut=%0d observed=%b expected=0", k, vld_w[k]);
          end
          if (k < 3) begin
            checks++;
            assert (done_w[k] === 1'b0) else begin
              fails++; $error("FAIL rst_done dut=%0d observed=%b expected=0", k, done_w[k]);
            end
          end
          last[k] = 32'h0;
        end else if (vld_w[k] === 1'b1) begin
          checks++;
          assert (sb_q[k].size() > 0) else begin
            fails++; $error("FAIL unexpected_vld dut=%0d cyc=%0d observed=1 expected=0", k, cyc);
          end
          if (sb_q[k].size() > 0) begin
            e = sb_q[k].pop_front();
            checks++;
            assert (dout_w[k] === e.data) else begin
              fails++; $error("FAIL rd_data dut=%0d observed=%h expected=%h", k, dout_w[k], e.data);
            end
            checks++;
            assert (cyc === e.due) else begin
              fails++; $error("FAIL rd_latency dut=%0d observed_cyc=%0d expected_cyc=%0d",
                              k, cyc, e.due);
            end
          end
          last[k] = dout_w[k];
        end else begin
          checks++;
          assert (vld_w[k] === 1'b0) else begin
            fails++; $error("FAIL vld_x dut=%0d observed=%b expected=0", k, vld_w[k]);
          end
          checks++;
          assert (dout_w[k] === last[k]) else begin
            fails++; $error("FAIL dout_hold dut=%0d observed=%h expected=%h", k, dout_w[k], last[k]);
          end
        end
      end
      checks++;
      assert (done_w[3] === 1'b1) else begin
        fails++; $error("FAIL noclr_done observed=%b expected=1", done_w[3]);
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; fails = 0;
    rst = 1'b1;
    re = 1'b0; we = 4'b0000; addr = 4'h0; din = 32'h0;
    re_d = 1'b0; we_d = 4'b0000; addr_d = 4'h0; din_d = 32'h0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    for (int k = 0; k < 4; k++) last[k] = 32'h0;

    // Clear after reset, then every entry reads zero
    repeat (3) step();
    rst = 1'b0;
    wait_clear();
    for (int i = 0; i < 16; i++) drive(1'b1, 4'b0000, 4'(i), 32'h0);
    idle(3);

    // Lane-masked write merge, read the following cycle
    drive(1'b0, 4'b1111, 4'd5, 32'hAABBCCDD);
    drive(1'b0, 4'b0101, 4'd5, 32'h11223344);
    drive(1'b1, 4'b0000, 4'd5, 32'h0);
    idle(3);

    // Read-during-write in each mode, full and partial lanes
    drive(1'b0, 4'b1111, 4'd7, 32'h12345678);
    idle(1);
    drive(1'b1, 4'b1111, 4'd7, 32'h9ABCDEF0);
    idle(2);
    drive(1'b1, 4'b0000, 4'd7, 32'h0);
    drive(1'b1, 4'b0011, 4'd7, 32'h55667788);
    drive(1'b1, 4'b0000, 4'd7, 32'h0);
    idle(3);

    // Back-to-back writes then streaming reads
    for (int i = 0; i < 16; i++) drive(1'b0, 4'b1111, 4'(i), 32'h01010101 * (i + 1) ^ 32'hC0DE0000);
    for (int i = 0; i < 16; i++) drive(1'b1, 4'b0000, 4'(i), 32'h0);
    idle(4);

    // Reset in the middle of the clear restarts it from address 0
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(9);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    wait_clear();
    drive(1'b1, 4'b0000, 4'd3, 32'h0);
    drive(1'b1, 4'b0000, 4'd12, 32'h0);
    idle(3);

    // No-clear instance is usable straight out of reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    drive_d(1'b0, 4'b1111, 4'd3, 32'hDEADBEEF);
    drive_d(1'b1, 4'b0000, 4'd3, 32'h0);
    drive_d(1'b1, 4'b1100, 4'd3, 32'h12340000);
    drive_d(1'b1, 4'b0000, 4'd3, 32'h0);
    idle(20);

    for (int k = 0; k < 4; k++) begin
      checks++;
      assert (sb_q[k].size() == 0) else begin
        fails++; $error("FAIL sb_drain dut=%0d observed_pending=%0d expected=0", k, sb_q[k].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
